// File: rtl/stim_gen_if.sv
// Stream bundle for the stimulus source: beat valid/ready handshake with payload and end-of-burst marker.
// Latency: none, this is wiring only.
// Backpressure: the slave drives out_ready; the master holds the beat until out_valid & out_ready.
interface stim_gen_if #(
   parameter int DATA_W = 8
) ();
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/stim_gen.sv
// Burst stimulus source: emits len beats of incrementing or Galois-LFSR data with optional idle gaps.
// Latency: first beat is valid in the cycle after the start edge; done pulses the cycle after the last handshake.
// Backpressure: out_ready low stalls the burst; data and last stay stable and valid is never withdrawn.
module stim_gen #(
   parameter int              DATA_W = 8,
   parameter int              CNT_W  = 16,
   parameter int              GAP_W  = 4,
   parameter logic [DATA_W-1:0] TAPS = 8'hB8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [CNT_W-1:0]  len,
   input  logic [GAP_W-1:0]  gap,
   input  logic [DATA_W-1:0] seed,
   stim_gen_if.master        strm,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  beat_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_nxt;

   // Configuration captured at start so later input changes cannot disturb a running burst.
   logic              mode_q;
   logic [CNT_W-1:0]  len_q;
   logic [GAP_W-1:0]  gap_q;

   logic [GAP_W-1:0]  gap_cnt;
   logic [DATA_W-1:0] data_q;

   logic              hs;
   logic              last_beat;
   logic              gap_en;
   logic [DATA_W-1:0] seed_eff;
   logic [DATA_W-1:0] data_nxt;

   assign hs        = strm.out_valid & strm.out_ready;
   assign last_beat = (beat_cnt == (len_q - CNT_W'(1)));
   assign gap_en    = (gap_q != '0);

   // An all-zero LFSR state never leaves zero, so a zero seed in LFSR mode is replaced by 1.
   assign seed_eff  = (mode && (seed == '0)) ? DATA_W'(1) : seed;

   // Successor payload: plain wrap-around increment, or one right-shift step of the Galois LFSR.
   assign data_nxt  = mode_q ? ((data_q >> 1) ^ (data_q[0] ? TAPS : '0))
                             : (data_q + DATA_W'(1));

   // State register; reset abandons any burst in flight without passing through FIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state decode; start is only looked at in IDLE, so start during a burst or in FIN is ignored.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_nxt = (len == '0) ? S_FIN : S_SEND;
            end
         end
         S_SEND: begin
            if (hs) begin
               if (last_beat) begin
                  state_nxt = S_FIN;
               end else if (gap_en) begin
                  state_nxt = S_GAP;
               end else begin
                  state_nxt = S_SEND;
               end
            end
         end
         S_GAP: begin
            // Counter is loaded with gap and leaves on 1, giving exactly gap idle cycles.
            if (gap_cnt == GAP_W'(1)) begin
               state_nxt = S_SEND;
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; FIN is a single cycle, so done is a one-cycle pulse with busy already low.
   always_comb begin
      strm.out_valid = 1'b0;
      strm.out_last  = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state_q)
         S_SEND: begin
            strm.out_valid = 1'b1;
            strm.out_last  = last_beat;
            busy           = 1'b1;
         end
         S_GAP: begin
            busy           = 1'b1;
         end
         S_FIN: begin
            done           = 1'b1;
         end
         default: begin
            busy           = 1'b0;
         end
      endcase
   end

   assign strm.out_data = data_q;

   // Datapath: capture config at start, advance payload and beat count on each accepted beat, run the gap timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= 1'b0;
         len_q    <= '0;
         gap_q    <= '0;
         gap_cnt  <= '0;
         data_q   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q   <= mode;
                  len_q    <= len;
                  gap_q    <= gap;
                  data_q   <= seed_eff;
                  beat_cnt <= '0;
               end
            end
            S_SEND: begin
               if (hs) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  data_q   <= data_nxt;
                  if (!last_beat && gap_en) begin
                     gap_cnt <= gap_q;
                  end
               end
            end
            S_GAP: begin
               gap_cnt <= gap_cnt - GAP_W'(1);
            end
            default: begin
               gap_cnt <= gap_cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: increment/LFSR data, gaps, backpressure, len=0, ignored starts, mid-burst reset.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready is driven directly by the bench to stall the source.
module tb_stim_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] len;
   logic [3:0]  gap;
   logic [7:0]  seed;
   logic        busy;
   logic        done;
   logic [15:0] beat_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   stim_gen_if #(.DATA_W(8)) sif ();

   stim_gen #(
      .DATA_W (8),
      .CNT_W  (16),
      .GAP_W  (4),
      .TAPS   (8'hB8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .len      (len),
      .gap      (gap),
      .seed     (seed),
      .strm     (sif),
      .busy     (busy),
      .done     (done),
      .beat_cnt (beat_cnt)
   );

   always #5 clk = ~clk;

   // Watchdog: the sequence is fixed-length, so reaching this means something stalled.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge; returns in the first cycle after the start edge.
   task automatic start_burst(input logic m, input logic [15:0] l, input logic [3:0] g, input logic [7:0] s);
      mode  = m;
      len   = l;
      gap   = g;
      seed  = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Checks n back-to-back beats (ready high, no gap) against exp, then the FIN cycle.
   task automatic run_stream(input string tag, input logic [7:0] exp [8], input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, 32'(sif.out_valid), 32'd1);
         chk({tag, "_data"},  32'(sif.out_data),  32'(exp[i]));
         chk({tag, "_last"},  32'(sif.out_last),  32'(i == n - 1));
         chk({tag, "_cnt"},   32'(beat_cnt),      32'(i));
         chk({tag, "_busy"},  32'(busy),          32'd1);
         tick();
      end
      chk({tag, "_done"},     32'(done),          32'd1);
      chk({tag, "_fin_busy"}, 32'(busy),          32'd0);
      chk({tag, "_fin_vld"},  32'(sif.out_valid), 32'd0);
      chk({tag, "_fin_cnt"},  32'(beat_cnt),      32'(n));
      tick();
      chk({tag, "_done_off"}, 32'(done),          32'd0);
      chk({tag, "_hold_cnt"}, 32'(beat_cnt),      32'(n));
   endtask

   initial begin
      logic [7:0] exp_d [8];
      logic [8:0] pat;
      int         b;

      rst           = 1'b1;
      start         = 1'b0;
      mode          = 1'b0;
      len           = '0;
      gap           = '0;
      seed          = '0;
      sif.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(sif.out_valid), 32'd0);
      chk("rst_last",  32'(sif.out_last),  32'd0);
      chk("rst_data",  32'(sif.out_data),  32'd0);
      chk("rst_busy",  32'(busy),          32'd0);
      chk("rst_done",  32'(done),          32'd0);
      chk("rst_cnt",   32'(beat_cnt),      32'd0);

      // Increment mode wraps FF -> 00.
      exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      start_burst(1'b0, 16'd4, 4'd0, 8'hFE);
      run_stream("inc", exp_d, 4);

      // LFSR with taps B8 from seed 01, then seed 0 must give the same sequence.
      exp_d = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'h00, 8'h00, 8'h00};
      start_burst(1'b1, 16'd5, 4'd0, 8'h01);
      run_stream("lfsr1", exp_d, 5);
      start_burst(1'b1, 16'd5, 4'd0, 8'h00);
      run_stream("lfsr0", exp_d, 5);

      // Gap of 3 between beats, none after the last.
      pat = 9'b1_0001_0001;
      b   = 0;
      start_burst(1'b0, 16'd3, 4'd3, 8'h10);
      for (int i = 0; i < 9; i++) begin
         chk("gap_valid", 32'(sif.out_valid), 32'(pat[i]));
         chk("gap_busy",  32'(busy),          32'd1);
         if (pat[i]) begin
            chk("gap_data", 32'(sif.out_data), 32'(8'h10 + 8'(b)));
            b++;
         end
         tick();
      end
      chk("gap_done", 32'(done),          32'd1);
      chk("gap_cnt",  32'(beat_cnt),      32'd3);
      tick();
      chk("gap_idle", 32'(sif.out_valid), 32'd0);

      // Backpressure: beat 0 stalled 5 cycles, last beat stalled 2 cycles.
      sif.out_ready = 1'b0;
      start_burst(1'b0, 16'd2, 4'd0, 8'h40);
      for (int i = 0; i < 5; i++) begin
         chk("bp0_valid", 32'(sif.out_valid), 32'd1);
         chk("bp0_data",  32'(sif.out_data),  32'h40);
         chk("bp0_last",  32'(sif.out_last),  32'd0);
         chk("bp0_cnt",   32'(beat_cnt),      32'd0);
         tick();
      end
      sif.out_ready = 1'b1;
      chk("bp0_data_acc", 32'(sif.out_data), 32'h40);
      tick();
      sif.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("bp1_valid", 32'(sif.out_valid), 32'd1);
         chk("bp1_data",  32'(sif.out_data),  32'h41);
         chk("bp1_last",  32'(sif.out_last),  32'd1);
         chk("bp1_cnt",   32'(beat_cnt),      32'd1);
         tick();
      end
      sif.out_ready = 1'b1;
      tick();
      chk("bp_done", 32'(done),     32'd1);
      chk("bp_cnt",  32'(beat_cnt), 32'd2);
      tick();

      // len=0: no beat, FIN straight after the start edge.
      start_burst(1'b0, 16'd0, 4'd0, 8'h77);
      chk("len0_valid", 32'(sif.out_valid), 32'd0);
      chk("len0_busy",  32'(busy),          32'd0);
      chk("len0_done",  32'(done),          32'd1);
      chk("len0_cnt",   32'(beat_cnt),      32'd0);
      tick();
      chk("len0_done_off", 32'(done),          32'd0);
      chk("len0_valid2",   32'(sif.out_valid), 32'd0);

      // Start and config changes during a burst and in FIN are ignored.
      start_burst(1'b0, 16'd3, 4'd0, 8'h20);
      chk("ign_d0", 32'(sif.out_data), 32'h20);
      start = 1'b1;
      mode  = 1'b1;
      len   = 16'd1;
      gap   = 4'd5;
      seed  = 8'h99;
      tick();
      chk("ign_d1",     32'(sif.out_data),  32'h21);
      chk("ign_valid1", 32'(sif.out_valid), 32'd1);
      start = 1'b0;
      tick();
      chk("ign_d2",   32'(sif.out_data), 32'h22);
      chk("ign_last", 32'(sif.out_last), 32'd1);
      tick();
      chk("ign_done", 32'(done),     32'd1);
      chk("ign_cnt",  32'(beat_cnt), 32'd3);
      start = 1'b1;
      len   = 16'd2;
      tick();
      start = 1'b0;
      chk("fin_start_valid", 32'(sif.out_valid), 32'd0);
      chk("fin_start_busy",  32'(busy),          32'd0);
      tick();
      chk("fin_start_valid2", 32'(sif.out_valid), 32'd0);
      chk("fin_start_done",   32'(done),          32'd0);

      // Reset during beat 2 of 6 aborts with no done pulse.
      start_burst(1'b0, 16'd6, 4'd0, 8'h30);
      chk("abort_d0", 32'(sif.out_data), 32'h30);
      tick();
      chk("abort_d1", 32'(sif.out_data), 32'h31);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", 32'(sif.out_valid), 32'd0);
      chk("abort_last",  32'(sif.out_last),  32'd0);
      chk("abort_data",  32'(sif.out_data),  32'd0);
      chk("abort_busy",  32'(busy),          32'd0);
      chk("abort_done",  32'(done),          32'd0);
      chk("abort_cnt",   32'(beat_cnt),      32'd0);
      tick();
      chk("abort_done2", 32'(done), 32'd0);
      exp_d = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_burst(1'b0, 16'd1, 4'd0, 8'h55);
      run_stream("post_rst", exp_d, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
